// File: rtl/fetch_queue_if.sv
// Fetch/decode handshake bundle for the instruction fetch queue.
// master drives fetch and decode inputs; slave is the queue itself.
interface fetch_queue_if #(
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          Flush_E;
  logic          Enq_Valid;
  logic          Enq_Ready;
  logic [31:0]   Instr_F;
  logic [31:0]   PC_F;
  logic [31:0]   PC_Plus_4_F;
  logic          Predict_Taken_F;
  logic          Valid_F;
  logic          Deq_Valid;
  logic          Deq_Ready;
  logic [31:0]   Instr_D;
  logic [31:0]   PC_D;
  logic [31:0]   PC_Plus_4_D;
  logic          Predict_Taken_D;
  logic          Valid_D;
  logic [CW-1:0] Count;

  modport master (
    output Flush_E, Enq_Valid, Instr_F, PC_F,
           PC_Plus_4_F, Predict_Taken_F, Valid_F,
           Deq_Ready,
    input  Enq_Ready, Deq_Valid, Instr_D, PC_D,
           PC_Plus_4_D, Predict_Taken_D, Valid_D,
           Count
  );

  modport slave (
    input  Flush_E, Enq_Valid, Instr_F, PC_F,
           PC_Plus_4_F, Predict_Taken_F, Valid_F,
           Deq_Ready,
    output Enq_Ready, Deq_Valid, Instr_D, PC_D,
           PC_Plus_4_D, Predict_Taken_D, Valid_D,
           Count
  );
endinterface

// File: rtl/fetch_queue.sv
// Instruction fetch queue between fetch and decode.
// Circular buffer with separate occupancy count; flush empties in one cycle.
module fetch_queue #(
  parameter int DEPTH = 4
) (
  input  logic         CLK,
  input  logic         RST,
  fetch_queue_if.slave q
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic        pt;
    logic        bv;
  } entry_t;

  entry_t        mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          full;
  logic          empty;
  logic          enq;
  logic          deq;
  entry_t        head;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign enq   = q.Enq_Valid && !full && !q.Flush_E;
  assign deq   = q.Deq_Ready && !empty && !q.Flush_E;

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (q.Flush_E) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (enq) wr_ptr <= wr_ptr + 1'b1;
      if (deq) rd_ptr <= rd_ptr + 1'b1;
      case ({enq, deq})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage is left uncleared; only pointers and count define validity.
  always_ff @(posedge CLK) begin
    if (!RST && enq) begin
      mem[wr_ptr] <= '{
        instr: q.Instr_F,
        pc:    q.PC_F,
        pc4:   q.PC_Plus_4_F,
        pt:    q.Predict_Taken_F,
        bv:    q.Valid_F
      };
    end
  end

  assign head        = mem[rd_ptr];
  assign q.Enq_Ready = !full;
  assign q.Deq_Valid = !empty;
  assign q.Count     = count;

  always_comb begin
    q.Instr_D         = 32'h0000_0013;
    q.PC_D            = '0;
    q.PC_Plus_4_D     = '0;
    q.Predict_Taken_D = 1'b0;
    q.Valid_D         = 1'b0;
    if (!empty) begin
      q.Instr_D         = head.instr;
      q.PC_D            = head.pc;
      q.PC_Plus_4_D     = head.pc4;
      q.Predict_Taken_D = head.pt;
      q.Valid_D         = head.bv;
    end
  end
endmodule
